// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/breakpoint sequencer and print buffer for the MIPS core
module cpu_run_ctrl #(
   parameter int PC_W       = 32,
   parameter int CNT_W      = 32,
   parameter int RESET_HOLD = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_btn,
   input  logic             step_btn,
   input  logic             stop_btn,
   input  logic             halt_req,
   input  logic [PC_W-1:0]  pc,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic             sys_print,
   input  logic [31:0]      sys_data,
   input  logic             disp_ready,
   output logic             pc_en,
   output logic             disp_valid,
   output logic [31:0]      disp_data,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycles,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_STEP  = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;
   localparam logic [2:0] S_HALT  = 3'd5;

   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   logic [2:0]       state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic             run_btn_q, step_btn_q, stop_btn_q;
   logic             bp_skip_q, bp_skip_d;
   logic [PC_W-1:0]  pc_prev_q;
   logic             disp_valid_q, disp_valid_d;
   logic [31:0]      disp_data_q, disp_data_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic edge_run, edge_step, edge_stop;
   logic bp_hit, prn_stall;

   // Button edges, breakpoint match, print stall and the commit enable
   always_comb begin
      edge_run  = run_btn & ~run_btn_q;
      edge_step = step_btn & ~step_btn_q;
      edge_stop = stop_btn & ~stop_btn_q;
      bp_hit    = bp_en & (pc == bp_addr) & ~bp_skip_q;
      prn_stall = sys_print & disp_valid_q & ~disp_ready;
      // State is reset asynchronously to IDLE, so pc_en falls with reset too
      pc_en     = ((state_q == S_RUN) | (state_q == S_STEP)) & ~halt_req & ~prn_stall
                  & ~((state_q == S_RUN) & bp_hit);
   end

   // Sequencer next state; buttons only matter in RUN, PAUSE and BREAK
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE: begin
            if (hold_q == HOLD_LAST) state_d = S_RUN;
            else                     hold_d  = hold_q + 1'b1;
         end
         S_RUN: begin
            if (halt_req)       state_d = S_HALT;
            else if (bp_hit)    state_d = S_BREAK;
            else if (edge_stop) state_d = S_PAUSE;
         end
         S_STEP: begin
            if (halt_req)   state_d = S_HALT;
            else if (pc_en) state_d = S_PAUSE;
         end
         S_PAUSE, S_BREAK: begin
            if (edge_run)       state_d = S_RUN;
            else if (edge_step) state_d = S_STEP;
         end
         default: state_d = state_q;
      endcase
   end

   // Breakpoint skip lets the stopped instruction execute once after leaving BREAK
   always_comb begin
      bp_skip_d = bp_skip_q;
      if ((state_q == S_BREAK) && (state_d != S_BREAK)) bp_skip_d = 1'b1;
      else if (pc_en || (pc != pc_prev_q))              bp_skip_d = 1'b0;
   end

   // Single-entry print buffer and activity counters
   always_comb begin
      disp_valid_d = disp_valid_q;
      disp_data_d  = disp_data_q;
      if (pc_en && sys_print) begin
         disp_valid_d = 1'b1;
         disp_data_d  = sys_data;
      end else if (disp_valid_q && disp_ready) begin
         disp_valid_d = 1'b0;
      end
      cycles_d  = ((state_q != S_IDLE) && (state_q != S_HALT)) ? cycles_q + 1'b1 : cycles_q;
      retired_d = pc_en ? retired_q + 1'b1 : retired_q;
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         run_btn_q    <= 1'b0;
         step_btn_q   <= 1'b0;
         stop_btn_q   <= 1'b0;
         bp_skip_q    <= 1'b0;
         pc_prev_q    <= '0;
         disp_valid_q <= 1'b0;
         disp_data_q  <= '0;
         cycles_q     <= '0;
         retired_q    <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         run_btn_q    <= run_btn;
         step_btn_q   <= step_btn;
         stop_btn_q   <= stop_btn;
         bp_skip_q    <= bp_skip_d;
         pc_prev_q    <= pc;
         disp_valid_q <= disp_valid_d;
         disp_data_q  <= disp_data_d;
         cycles_q     <= cycles_d;
         retired_q    <= retired_d;
      end
   end

   assign state      = state_q;
   assign disp_valid = disp_valid_q;
   assign disp_data  = disp_data_q;
   assign cycles     = cycles_q;
   assign retired    = retired_q;

endmodule
